instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
- Parametrised successor to the fetch-side instruction ROM: a loadable instruction memory with synchronous read and a valid/ready fetch handshake.
- After reset the block accepts a program image through a word-wide load port, then switches to RUN and serves fetches from the PC datapath with 1-cycle latency.
- Flags misaligned and out-of-range fetches instead of returning garbage.
- Sits between the PC/fetch stage and decode; the load port is driven by the testbench or boot logic.

Parameters:
- INSTR_WIDTH, 32, instruction word width in bits.
- ADDRESS_WIDTH, 32, byte-address width of FetchAddr and LoadAddr.
- MEM_DEPTH, 256, number of instruction words stored.
- NOP_WORD, 32'h0000_0000, data returned on a faulted fetch.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- LoadValid  input  1  load word present this cycle.
- LoadAddr  input  ADDRESS_WIDTH  byte address of load word.
- LoadData  input  INSTR_WIDTH  instruction word to store.
- LoadDone  input  1  end of program image; enter RUN.
- LoadCount  output  $clog2(MEM_DEPTH+1)  number of accepted load writes, saturating.
- FetchReq  input  1  fetch request.
- FetchAddr  input  ADDRESS_WIDTH  byte address (PC).
- FetchReady  output  1  request accepted when FetchReq & FetchReady.
- RespValid  output  1  response valid.
- RespData  output  INSTR_WIDTH  fetched instruction.
- RespFault  output  1  response is for a misaligned or out-of-range address.
- RespReady  input  1  consumer accepts response.
- Running  output  1  high in RUN state.

Behaviour:
- Reset (RST=0, async):
  - State LOAD; RespValid=0, RespData=0, RespFault=0, LoadCount=0, Running=0, FetchReady=0.
  - Memory array is not cleared.
  - Reset mid-transfer discards any pending response with no output glitch beyond the async clear.
- State LOAD:
  - On LoadValid, word index = LoadAddr>>2.
  - If LoadAddr[1:0]==0 and index<MEM_DEPTH: write the word and increment LoadCount (saturate at MEM_DEPTH). Otherwise drop the write silently with no count.
  - FetchReady=0.
  - LoadDone moves to RUN next cycle. If LoadValid and LoadDone arrive together, the write completes first.
- State RUN:
  - LoadValid and LoadDone are ignored.
  - Stays in RUN until reset; there is no return path to LOAD.
- Handshake:
  - FetchReady = Running & (!RespValid | RespReady), giving a single-entry output register with full throughput.
  - Request accepted at edge N produces RespValid=1 after edge N, with data = ROM[FetchAddr>>2].
  - RespValid/RespData/RespFault hold stable while RespValid & !RespReady.
  - On a cycle with RespReady and no new accept, RespValid falls.
  - Accept and consume in the same cycle replaces the response; back-to-back fetches give 1 word/cycle.
- Fault:
  - FetchAddr[1:0]!=0 or (FetchAddr>>2)>=MEM_DEPTH gives RespFault=1 and RespData=NOP_WORD.
  - A faulted fetch still completes the handshake normally.
- Width rules:
  - Index is computed at full ADDRESS_WIDTH before the compare; no truncation aliasing.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit computed on load.
  - On fetch, a mismatch sets an extra output RespParityErr, sampled with RespData and held under the same rules.
  - Faulted fetches report RespParityErr=0.
  - Reset value 0.
- Undefined:
  - No parity storage and no RespParityErr port.
  - Behaviour is otherwise identical.

Decomposition:
- Package imem_pkg holds the state encoding (LOAD, RUN), the default NOP_WORD constant, and a function computing word index and in-range/aligned check.
- One sub-module, imem_array: a synchronous-write, synchronous-read RAM of MEM_DEPTH x (INSTR_WIDTH + optional parity bit).
- The controller holds the FSM, counter, handshake and fault logic.

Test Plan:
- Reset, load words 0x20080005 @0x0 and 0x20090007 @0x4, LoadDone, then fetch 0x0, 0x4 back-to-back with RespReady=1:
  - LoadCount=2.
  - Responses 0x20080005 then 0x20090007 on consecutive cycles.
  - RespFault=0.
- Fetch in LOAD state:
  - FetchReady=0 throughout, no RespValid.
  - After LoadDone, FetchReady=1 the next cycle.
- Back-pressure: fetch 0x0, hold RespReady=0 for 3 cycles:
  - RespValid and RespData stable.
  - FetchReady=0.
  - Raising RespReady with a new FetchReq @0x4 gives the next word the following cycle.
- Fetch 0x2 and fetch MEM_DEPTH*4 (0x400 at default):
  - RespFault=1, RespData=0x00000000.
  - Handshake completes.
- Load at 0x401 and at 0x3FC plus LoadDone in the same cycle:
  - Only 0x3FC is written; LoadCount increments by 1.
  - Fetch 0x3FC returns the loaded word.
- Assert RST mid-stream with RespValid=1:
  - Outputs clear immediately; state is LOAD.
  - Memory retains contents: fetch after re-LoadDone with no loads returns the previous word.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory controller: controller state
// encoding, the default NOP word, and address-to-word-index helpers.
package imem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Word index of a byte address, kept at full width so nothing aliases.
  function automatic logic [63:0] word_index(input logic [63:0] addr);
    return addr >> 2;
  endfunction

  // Address is word aligned and its word index lies inside the memory.
  function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Load and fetch bus of the instruction memory controller.
// master: boot/test load source plus PC fetch stage and decode consumer.
// slave : instr_mem_ctrl.
// RespParityErr exists only when IMEM_PARITY_EN is defined.
interface instr_mem_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH     = 256
);
  localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);

  logic                     LoadValid;
  logic [ADDRESS_WIDTH-1:0] LoadAddr;
  logic [INSTR_WIDTH-1:0]   LoadData;
  logic                     LoadDone;
  logic [CNT_W-1:0]         LoadCount;
  logic                     FetchReq;
  logic [ADDRESS_WIDTH-1:0] FetchAddr;
  logic                     FetchReady;
  logic                     RespValid;
  logic [INSTR_WIDTH-1:0]   RespData;
  logic                     RespFault;
  logic                     RespReady;
  logic                     Running;
`ifdef IMEM_PARITY_EN
  logic                     RespParityErr;
`endif

  modport master (
    output LoadValid, LoadAddr, LoadData, LoadDone, FetchReq, FetchAddr, RespReady,
    input  LoadCount, FetchReady, RespValid, RespData, RespFault, Running
`ifdef IMEM_PARITY_EN
    , RespParityErr
`endif
  );

  modport slave (
    input  LoadValid, LoadAddr, LoadData, LoadDone, FetchReq, FetchAddr, RespReady,
    output LoadCount, FetchReady, RespValid, RespData, RespFault, Running
`ifdef IMEM_PARITY_EN
    , RespParityErr
`endif
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, synchronous read with enable.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata write
// port, re/raddr read port, rdata registered read data held while re=0.
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents survive reset so a program image outlives a soft restart.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the response data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory with a valid/ready fetch port.
// After reset it accepts words on the load port until LoadDone, then serves
// fetches with one cycle latency through a single-entry response register.
// Misaligned or out-of-range fetches return NOP_WORD with RespFault set.
// Ports: CLK, RST (async active-low), bus (instr_mem_ctrl_if.slave).
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and
// report mismatches on RespParityErr.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned            INSTR_WIDTH   = 32,
  parameter int unsigned            ADDRESS_WIDTH = 32,
  parameter int unsigned            MEM_DEPTH     = 256,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD      = INSTR_WIDTH'(NOP_WORD_DEFAULT)
) (
  input logic         CLK,
  input logic         RST,
  instr_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
`ifdef IMEM_PARITY_EN
  localparam int unsigned WORD_W = INSTR_WIDTH + 1;
`else
  localparam int unsigned WORD_W = INSTR_WIDTH;
`endif

  state_e                   state;
  logic                     resp_valid;
  logic                     resp_fault;
  logic [CNT_W-1:0]         load_count;
  logic [ADDRESS_WIDTH-1:0] load_addr;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic                     load_ok_c;
  logic                     fetch_ok_c;
  logic                     fetch_ready_c;
  logic                     accept_c;
  logic                     we_c;
  logic                     re_c;
  logic [IDX_W-1:0]         waddr_c;
  logic [IDX_W-1:0]         raddr_c;
  logic [WORD_W-1:0]        wdata_c;
  logic [WORD_W-1:0]        rd_word;

  assign load_addr  = bus.LoadAddr;
  assign fetch_addr = bus.FetchAddr;

  // Range checks run on the full-width index before truncation to IDX_W.
  assign load_ok_c  = addr_ok(64'(load_addr), 64'(MEM_DEPTH));
  assign fetch_ok_c = addr_ok(64'(fetch_addr), 64'(MEM_DEPTH));
  assign waddr_c    = IDX_W'(word_index(64'(load_addr)));
  assign raddr_c    = IDX_W'(word_index(64'(fetch_addr)));

`ifdef IMEM_PARITY_EN
  assign wdata_c = {^bus.LoadData, bus.LoadData};
`else
  assign wdata_c = bus.LoadData;
`endif

  // Single-entry output register: free, or being drained this cycle.
  assign fetch_ready_c = (state == ST_RUN) & (~resp_valid | bus.RespReady);
  assign accept_c      = bus.FetchReq & fetch_ready_c;
  assign we_c          = (state == ST_LOAD) & bus.LoadValid & load_ok_c;
  assign re_c          = accept_c & fetch_ok_c;

  // Controller state, load counter and response-valid tracking.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_LOAD;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      load_count <= '0;
    end else if (state == ST_LOAD) begin
      if (we_c && (load_count != CNT_W'(MEM_DEPTH))) load_count <= load_count + CNT_W'(1);
      if (bus.LoadDone) state <= ST_RUN;
    end else begin
      if (accept_c) begin
        resp_valid <= 1'b1;
        resp_fault <= ~fetch_ok_c;
      end else if (bus.RespReady) begin
        resp_valid <= 1'b0;
      end
    end
  end

  imem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (WORD_W)
  ) u_array (
    .clk   (CLK),
    .rst_n (RST),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .re    (re_c),
    .raddr (raddr_c),
    .rdata (rd_word)
  );

  assign bus.LoadCount  = load_count;
  assign bus.FetchReady = fetch_ready_c;
  assign bus.RespValid  = resp_valid;
  assign bus.RespFault  = resp_fault;
  assign bus.RespData   = resp_fault ? NOP_WORD : rd_word[INSTR_WIDTH-1:0];
  assign bus.Running    = (state == ST_RUN);
`ifdef IMEM_PARITY_EN
  // Stored word plus its even-parity bit must XOR to zero.
  assign bus.RespParityErr = ~resp_fault & (^rd_word);
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed scenarios plus randomized
// load and fetch traffic against an array/queue reference model.
module tb_instr_mem_ctrl;

  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_DEPTH(DEPTH)) bus ();

  instr_mem_ctrl #(
    .INSTR_WIDTH   (IW),
    .ADDRESS_WIDTH (AW),
    .MEM_DEPTH     (DEPTH),
    .NOP_WORD      (NOP)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          ref_wr  [DEPTH];
  int          ref_count = 0;
  int unsigned wr_list[$];

  // Reference load rule: aligned, in range, counter saturates at DEPTH.
  function automatic void model_load(input logic [31:0] a, input logic [31:0] d);
    longint unsigned idx;
    idx = longint'(a) / 4;
    if ((a % 4) == 0 && idx < DEPTH) begin
      if (!ref_wr[idx]) wr_list.push_back(int'(idx));
      ref_wr[idx]  = 1'b1;
      ref_mem[idx] = d;
      if (ref_count < DEPTH) ref_count++;
    end
  endfunction

  function automatic void expect_fetch(input logic [31:0] a, output logic [31:0] d, output logic f);
    longint unsigned idx;
    idx = longint'(a) / 4;
    if ((a % 4) != 0 || idx >= DEPTH) begin
      d = NOP;
      f = 1'b1;
    end else begin
      d = ref_mem[idx];
      f = 1'b0;
    end
  endfunction

  task automatic idle_inputs();
    bus.LoadValid = 1'b0;
    bus.LoadAddr  = '0;
    bus.LoadData  = '0;
    bus.LoadDone  = 1'b0;
    bus.FetchReq  = 1'b0;
    bus.FetchAddr = '0;
    bus.RespReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_count = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.RespValid); end
    n_checks++; if (bus.RespData !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.RespData); end
    n_checks++; if (bus.RespFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus.RespFault); end
    n_checks++; if (bus.LoadCount !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.LoadCount); end
    n_checks++; if (bus.Running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", bus.Running); end
    n_checks++; if (bus.FetchReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.FetchReady); end
    rst_n = 1'b1;
    ref_count = 0;
    tick();
    n_checks++; if (bus.Running !== 1'b0) begin n_fail++; $display("FAIL post_reset_load: got running=%b want 0", bus.Running); end
  endtask

  task automatic test_fetch_in_load();
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h0;
    for (int c = 0; c < 4; c++) begin
      bus.LoadValid = (c < 2);
      bus.LoadAddr  = (c == 0) ? 32'h0 : 32'h4;
      bus.LoadData  = (c == 0) ? 32'h2008_0005 : 32'h2009_0007;
      if (c < 2) model_load(bus.LoadAddr, bus.LoadData);
      @(negedge clk);
      n_checks++; if (bus.FetchReady !== 1'b0) begin n_fail++; $display("FAIL load_ready c%0d: got %b want 0", c, bus.FetchReady); end
      n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL load_valid c%0d: got %b want 0", c, bus.RespValid); end
      tick();
    end
    bus.LoadValid = 1'b0;
    bus.FetchReq  = 1'b0;
    bus.LoadDone  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.FetchReady !== 1'b0) begin n_fail++; $display("FAIL done_cycle_ready: got %b want 0", bus.FetchReady); end
    tick();
    bus.LoadDone = 1'b0;
    n_checks++; if (bus.FetchReady !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b want 1", bus.FetchReady); end
    n_checks++; if (bus.Running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b want 1", bus.Running); end
    n_checks++; if (bus.LoadCount !== CW'(ref_count)) begin n_fail++; $display("FAIL load_count: got %0d want %0d", bus.LoadCount, ref_count); end
  endtask

  task automatic test_back_to_back();
    bus.RespReady = 1'b1;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h0;
    tick();
    bus.FetchAddr = 32'h4;
    n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2008_0005 || bus.RespFault !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got v=%b d=%h f=%b want 1 20080005 0", bus.RespValid, bus.RespData, bus.RespFault); end
    n_checks++; if (bus.FetchReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.FetchReady); end
    tick();
    bus.FetchReq = 1'b0;
    n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2009_0007 || bus.RespFault !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got v=%b d=%h f=%b want 1 20090007 0", bus.RespValid, bus.RespData, bus.RespFault); end
    tick();
    n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.RespValid); end
  endtask

  task automatic test_backpressure();
    bus.RespReady = 1'b0;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h0;
    tick();
    bus.FetchAddr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2008_0005) begin
        n_fail++; $display("FAIL bp_hold c%0d: got v=%b d=%h want 1 20080005", c, bus.RespValid, bus.RespData); end
      n_checks++; if (bus.FetchReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0", c, bus.FetchReady); end
      tick();
    end
    bus.RespReady = 1'b1;
    #1;
    n_checks++; if (bus.FetchReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.FetchReady); end
    tick();
    bus.FetchReq = 1'b0;
    n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2009_0007) begin
      n_fail++; $display("FAIL bp_next: got v=%b d=%h want 1 20090007", bus.RespValid, bus.RespData); end
    tick();
    n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.RespValid); end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [6];
    addrs[0] = 32'h2;
    addrs[1] = 32'(DEPTH * 4);
    addrs[2] = 32'h4000_0000;
    addrs[3] = 32'hFFFF_FFFE;
    addrs[4] = 32'h3FD;
    addrs[5] = ($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
    bus.RespReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.FetchReq  = 1'b1;
      bus.FetchAddr = addrs[i];
      tick();
      bus.FetchReq = 1'b0;
      n_checks++; if (bus.RespValid !== 1'b1 || bus.RespFault !== 1'b1 || bus.RespData !== NOP) begin
        n_fail++; $display("FAIL fault %h: got v=%b f=%b d=%h want 1 1 %h", addrs[i], bus.RespValid, bus.RespFault, bus.RespData, NOP); end
      tick();
      n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL fault_done %h: got v=%b want 0", addrs[i], bus.RespValid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w_bad;
    logic [31:0] w_top;
    w_bad = $urandom;
    w_top = $urandom;
    bus.RespReady = 1'b0;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h4;
    tick();
    bus.FetchReq = 1'b0;
    n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2009_0007) begin
      n_fail++; $display("FAIL mid_pending: got v=%b d=%h want 1 20090007", bus.RespValid, bus.RespData); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.RespValid !== 1'b0 || bus.RespData !== 32'h0 || bus.RespFault !== 1'b0) begin
      n_fail++; $display("FAIL mid_clear: got v=%b d=%h f=%b want 0 0 0", bus.RespValid, bus.RespData, bus.RespFault); end
    n_checks++; if (bus.Running !== 1'b0 || bus.FetchReady !== 1'b0 || bus.LoadCount !== CW'(0)) begin
      n_fail++; $display("FAIL mid_state: got run=%b rdy=%b cnt=%0d want 0 0 0", bus.Running, bus.FetchReady, bus.LoadCount); end
    @(negedge clk);
    rst_n = 1'b1;
    ref_count = 0;
    idle_inputs();
    tick();
    bus.LoadValid = 1'b1;
    bus.LoadAddr  = 32'h401;
    bus.LoadData  = w_bad;
    model_load(bus.LoadAddr, bus.LoadData);
    tick();
    bus.LoadAddr = 32'h3FC;
    bus.LoadData = w_top;
    bus.LoadDone = 1'b1;
    model_load(bus.LoadAddr, bus.LoadData);
    tick();
    idle_inputs();
    n_checks++; if (bus.LoadCount !== CW'(ref_count)) begin n_fail++; $display("FAIL edge_count: got %0d want %0d", bus.LoadCount, ref_count); end
    n_checks++; if (bus.Running !== 1'b1) begin n_fail++; $display("FAIL edge_run: got %b want 1", bus.Running); end
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h3FC;
    tick();
    bus.FetchAddr = 32'h0;
    n_checks++; if (bus.RespData !== w_top || bus.RespFault !== 1'b0) begin
      n_fail++; $display("FAIL edge_top: got d=%h f=%b want %h 0", bus.RespData, bus.RespFault, w_top); end
    tick();
    bus.FetchReq = 1'b0;
    n_checks++; if (bus.RespData !== 32'h2008_0005) begin n_fail++; $display("FAIL retain0: got %h want 20080005", bus.RespData); end
    do_reset();
    bus.LoadDone = 1'b1;
    tick();
    bus.LoadDone  = 1'b0;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'h4;
    n_checks++; if (bus.LoadCount !== CW'(0)) begin n_fail++; $display("FAIL reload_count: got %0d want 0", bus.LoadCount); end
    tick();
    bus.FetchReq = 1'b0;
    n_checks++; if (bus.RespValid !== 1'b1 || bus.RespData !== 32'h2009_0007) begin
      n_fail++; $display("FAIL retain4: got v=%b d=%h want 1 20090007", bus.RespValid, bus.RespData); end
    tick();
  endtask

  task automatic test_random();
    resp_t       q[$];
    resp_t       r;
    logic [31:0] a;
    logic        do_pop;
    logic        do_push;
    logic        exp_rdy;
    int          start_count;
    do_reset();
    for (int i = 0; i < 360; i++) begin
      case ($urandom % 10)
        8:       a = ($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
        9:       a = $urandom | 32'h0000_0400;
        default: a = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      bus.LoadValid = 1'b1;
      bus.LoadAddr  = a;
      bus.LoadData  = $urandom;
      model_load(bus.LoadAddr, bus.LoadData);
      tick();
    end
    bus.LoadValid = 1'b0;
    bus.LoadDone  = 1'b1;
    tick();
    bus.LoadDone = 1'b0;
    n_checks++; if (bus.LoadCount !== CW'(ref_count)) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", bus.LoadCount, ref_count); end
    start_count = ref_count;
    for (int i = 0; i < 400; i++) begin
      bus.FetchReq = ($urandom % 4) != 0;
      if (($urandom % 5) != 0) a = wr_list[$urandom % wr_list.size()] * 4;
      else if ($urandom % 2)   a = $urandom | 32'h1;
      else                     a = $urandom | 32'h0000_0400;
      bus.FetchAddr = a;
      bus.RespReady = ($urandom % 3) != 0;
      bus.LoadValid = ($urandom % 4) == 0;
      bus.LoadAddr  = $urandom_range(0, DEPTH - 1) * 4;
      bus.LoadData  = $urandom;
      bus.LoadDone  = ($urandom % 8) == 0;
      @(negedge clk);
      n_checks++; if (bus.RespValid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid %0d: got %b want %b", i, bus.RespValid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (bus.RespData !== q[0].data || bus.RespFault !== q[0].fault) begin
          n_fail++; $display("FAIL rand_resp %0d: got d=%h f=%b want %h %b", i, bus.RespData, bus.RespFault, q[0].data, q[0].fault); end
      end
      exp_rdy = (q.size() == 0) || bus.RespReady;
      n_checks++; if (bus.FetchReady !== exp_rdy) begin n_fail++; $display("FAIL rand_ready %0d: got %b want %b", i, bus.FetchReady, exp_rdy); end
      do_pop  = (q.size() != 0) && bus.RespReady;
      do_push = bus.FetchReq && exp_rdy;
      a       = bus.FetchAddr;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        expect_fetch(a, r.data, r.fault);
        q.push_back(r);
      end
      #1;
    end
    idle_inputs();
    tick();
    tick();
    n_checks++; if (bus.RespValid !== 1'b0 || bus.LoadCount !== CW'(start_count)) begin
      n_fail++; $display("FAIL rand_end: got v=%b cnt=%0d want 0 %0d", bus.RespValid, bus.LoadCount, start_count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_in_load();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
